// File: rtl/fu_complete_arbiter_pkg.sv
// fu_complete_arbiter_pkg: shared sizes, the FU completion packet and a modulo-NUM_FU pointer helper
package fu_complete_arbiter_pkg;
    localparam int NUM_FU = 5;
    localparam int WAYS   = 3;
    localparam int PTR_W  = $clog2(NUM_FU);

    typedef struct packed {
        logic       valid;
        logic       take_branch;
        logic [5:0] pr_idx;
        logic [4:0] rob_idx;
    } FU_COMPLETE_PACKET;

    typedef FU_COMPLETE_PACKET [NUM_FU-1:0] fu_in_vec_t;
    typedef FU_COMPLETE_PACKET [WAYS-1:0]   fu_out_vec_t;

    // p and n are both below NUM_FU, so a single conditional subtract wraps correctly
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [PTR_W-1:0] n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + {1'b0, n};
        return (s >= (PTR_W+1)'(NUM_FU)) ? PTR_W'(s - (PTR_W+1)'(NUM_FU)) : s[PTR_W-1:0];
    endfunction
endpackage

// File: rtl/fu_complete_arbiter_if.sv
// fu_complete_arbiter_if: FU result bus, per-FU stall and completion packets
//   fu_complete_in  : per-FU result packets (FU side drives)
//   fu_stall        : per-FU hold request (arbiter drives)
//   complete_fu_out : registered completion packets (arbiter drives)
interface fu_complete_arbiter_if;
    import fu_complete_arbiter_pkg::*;
    fu_in_vec_t             fu_complete_in;
    logic [NUM_FU-1:0]      fu_stall;
    fu_out_vec_t            complete_fu_out;

    modport master (output fu_complete_in, input fu_stall, input complete_fu_out);
    modport slave  (input fu_complete_in, output fu_stall, output complete_fu_out);
endinterface

// File: rtl/fu_complete_arbiter_rr_select.sv
// complete_rr_select: round-robin pick of up to WAYS requesters starting at the pointer
//   i_req      : per-FU request
//   i_rr_ptr   : first index scanned
//   o_gnt_sel  : per-slot one-hot FU select
//   o_slot_v   : slot carries a grant
//   o_next_ptr : one past the last granted index, or i_rr_ptr if none
module complete_rr_select
    import fu_complete_arbiter_pkg::*;
(
    input  logic [NUM_FU-1:0]            i_req,
    input  logic [PTR_W-1:0]             i_rr_ptr,
    output logic [WAYS-1:0][NUM_FU-1:0]  o_gnt_sel,
    output logic [WAYS-1:0]              o_slot_v,
    output logic [PTR_W-1:0]             o_next_ptr
);
    localparam int CNT_W = $clog2(WAYS+1);
    localparam logic [CNT_W-1:0] WAYS_C = CNT_W'(WAYS);

    logic [CNT_W-1:0] w_cnt;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_gnt_sel  = '0;
        o_slot_v   = '0;
        o_next_ptr = i_rr_ptr;
        w_cnt      = '0;
        w_idx      = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            w_idx = ptr_add(i_rr_ptr, PTR_W'(j));
            if (i_req[w_idx] && w_cnt < WAYS_C) begin
                o_gnt_sel[w_cnt][w_idx] = 1'b1;
                o_slot_v[w_cnt]         = 1'b1;
                o_next_ptr              = ptr_add(w_idx, PTR_W'(1));
                w_cnt                   = w_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fu_complete_arbiter.sv
// fu_complete_arbiter: forwards up to WAYS FU results per cycle, buffering and stalling losers
//   clock  : system clock
//   reset  : synchronous active-high reset
//   squash : synchronous flush of held and in-flight results
//   bus    : fu_complete_in in, fu_stall / complete_fu_out out
module fu_complete_arbiter
    import fu_complete_arbiter_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  squash,
    fu_complete_arbiter_if.slave  bus
);
    FU_COMPLETE_PACKET            r_hold [NUM_FU];
    logic [NUM_FU-1:0]            r_hold_v;
    logic [PTR_W-1:0]             r_rr_ptr;
    fu_out_vec_t                  r_out;

    logic [NUM_FU-1:0]            w_req;
    FU_COMPLETE_PACKET            w_cand [NUM_FU];
    logic [WAYS-1:0][NUM_FU-1:0]  w_gnt_sel;
    logic [WAYS-1:0]              w_slot_v;
    logic [PTR_W-1:0]             w_next_ptr;
    logic [NUM_FU-1:0]            w_gnt_any;
    fu_out_vec_t                  w_out;

    assign bus.fu_stall        = r_hold_v;
    assign bus.complete_fu_out = r_out;

    // a held entry masks whatever the stalled FU is presenting
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            w_req[i]  = r_hold_v[i] | bus.fu_complete_in[i].valid;
            w_cand[i] = r_hold_v[i] ? r_hold[i] : bus.fu_complete_in[i];
        end
    end

    complete_rr_select u_sel (
        .i_req      (w_req),
        .i_rr_ptr   (r_rr_ptr),
        .o_gnt_sel  (w_gnt_sel),
        .o_slot_v   (w_slot_v),
        .o_next_ptr (w_next_ptr)
    );

    always_comb begin
        w_out     = '0;
        w_gnt_any = '0;
        for (int k = 0; k < WAYS; k++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_slot_v[k] && w_gnt_sel[k][i]) begin
                    w_out[k]     = w_out[k] | w_cand[i];
                    w_gnt_any[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out    <= '0;
            r_hold_v <= '0;
            r_rr_ptr <= '0;
        end else if (squash) begin
            r_out    <= '0;
            r_hold_v <= '0;
        end else begin
            r_out    <= w_out;
            r_rr_ptr <= w_next_ptr;
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_gnt_any[i]) begin
                    r_hold_v[i] <= 1'b0;
                end else if (w_req[i]) begin
                    r_hold[i]   <= w_cand[i];
                    r_hold_v[i] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fu_complete_arbiter.sv
// tb_fu_complete_arbiter: directed and random checks against a queue-based reference model
module tb_fu_complete_arbiter;
    import fu_complete_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic squash;
    always #5 clk = ~clk;

    fu_complete_arbiter_if bus();

    fu_complete_arbiter dut (
        .clock  (clk),
        .reset  (rst),
        .squash (squash),
        .bus    (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    FU_COMPLETE_PACKET m_hold [NUM_FU];
    bit                m_hv   [NUM_FU];
    int                m_ptr  = 0;
    fu_out_vec_t       m_out  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic FU_COMPLETE_PACKET mk(input bit tb, input int pr, input int rob);
        FU_COMPLETE_PACKET p;
        p.valid       = 1'b1;
        p.take_branch = tb;
        p.pr_idx      = 6'(pr);
        p.rob_idx     = 5'(rob);
        return p;
    endfunction

    // reference: walk FUs in order from the pointer, the first WAYS requesters win
    task automatic model(input bit rs, input bit sq, input fu_in_vec_t in);
        int                g[$];
        FU_COMPLETE_PACKET c [NUM_FU];
        bit                rq [NUM_FU];
        m_out = '0;
        if (rs) begin
            foreach (m_hv[i]) m_hv[i] = 0;
            m_ptr = 0;
            return;
        end
        if (sq) begin
            foreach (m_hv[i]) m_hv[i] = 0;
            return;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            rq[i] = m_hv[i] || in[i].valid;
            c[i]  = m_hv[i] ? m_hold[i] : in[i];
        end
        for (int j = 0; j < NUM_FU; j++) begin
            int i;
            i = (m_ptr + j) % NUM_FU;
            if (rq[i]) begin
                if (g.size() < WAYS) begin
                    m_out[g.size()] = c[i];
                    g.push_back(i);
                    m_hv[i] = 0;
                end else begin
                    m_hold[i] = c[i];
                    m_hv[i]   = 1;
                end
            end
        end
        if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % NUM_FU;
    endtask

    task automatic check_model(input string tag);
        logic [NUM_FU-1:0] st;
        for (int i = 0; i < NUM_FU; i++) st[i] = m_hv[i];
        chk({tag, "_out"},   bus.complete_fu_out, m_out);
        chk({tag, "_stall"}, bus.fu_stall, st);
        chk({tag, "_ptr"},   dut.r_rr_ptr, m_ptr);
    endtask

    task automatic step(input bit rs, input bit sq, input fu_in_vec_t in, input string tag);
        @(negedge clk);
        rst                = rs;
        squash             = sq;
        bus.fu_complete_in = in;
        model(rs, sq, in);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        fu_in_vec_t        v;
        fu_in_vec_t        all;
        FU_COMPLETE_PACKET orig;
        rst = 1'b1;
        squash = 1'b0;
        for (int i = 0; i < NUM_FU; i++) all[i] = mk(0, 10 + i, 20 + i);
        bus.fu_complete_in = all;

        step(1, 0, all, "rst_a");
        step(1, 0, all, "rst_b");
        chk("rst_out_zero", bus.complete_fu_out, '0);
        chk("rst_stall_zero", bus.fu_stall, 5'b00000);

        v = '0; v[1] = mk(0, 1, 4); v[3] = mk(0, 2, 7);
        step(0, 0, v, "t2");
        chk("t2_o0", bus.complete_fu_out[0], mk(0, 1, 4));
        chk("t2_o1", bus.complete_fu_out[1], mk(0, 2, 7));
        chk("t2_o2_v", bus.complete_fu_out[2].valid, 1'b0);
        chk("t2_ptr", dut.r_rr_ptr, 4);

        step(1, 0, all, "t3_rst");
        step(0, 0, all, "t3_all");
        chk("t3_o0", bus.complete_fu_out[0], all[0]);
        chk("t3_o2", bus.complete_fu_out[2], all[2]);
        chk("t3_stall", bus.fu_stall, 5'b11000);
        chk("t3_ptr", dut.r_rr_ptr, 3);
        v = '0; for (int i = 0; i < 3; i++) v[i] = mk(1, 40 + i, 30 + i);
        step(0, 0, v, "t3_new");
        chk("t3b_o0", bus.complete_fu_out[0], all[3]);
        chk("t3b_o1", bus.complete_fu_out[1], all[4]);
        chk("t3b_o2", bus.complete_fu_out[2], v[0]);
        chk("t3b_stall", bus.fu_stall, 5'b00110);
        chk("t3b_ptr", dut.r_rr_ptr, 1);

        step(0, 0, '0, "t4_drain");
        v = '0; v[3] = mk(0, 5, 5);
        step(0, 0, v, "t4_to4");
        chk("t4_ptr_pre", dut.r_rr_ptr, 4);
        v = '0; v[4] = mk(0, 9, 1); v[0] = mk(0, 12, 2);
        step(0, 0, v, "t4");
        chk("t4_o0_pr", bus.complete_fu_out[0].pr_idx, 9);
        chk("t4_o1_pr", bus.complete_fu_out[1].pr_idx, 12);
        chk("t4_ptr_wrap", dut.r_rr_ptr, 1);
        step(0, 0, '0, "t4_idle");
        chk("idle_out_zero", bus.complete_fu_out, '0);

        step(1, 0, '0, "t5_rst");
        step(0, 0, all, "t5_fill");
        v = '0; v[2] = mk(0, 3, 5);
        step(0, 1, v, "t5_sq");
        chk("t5_out_zero", bus.complete_fu_out, '0);
        chk("t5_stall", bus.fu_stall, 5'b00000);
        chk("t5_ptr", dut.r_rr_ptr, 3);
        for (int n = 0; n < 3; n++) begin
            step(0, 0, '0, "t5_after");
            chk("t5_no_rob5", bus.complete_fu_out[0].valid, 1'b0);
        end

        step(1, 0, '0, "t6_rst");
        all[3] = mk(1, 6'h2A, 5'h13);
        orig = all[3];
        step(0, 0, all, "t6_fill");
        v = '0; v[3] = mk(0, 6'h01, 5'h02);
        step(0, 0, v, "t6_stalled");
        chk("t6_orig", bus.complete_fu_out[0], orig);
        chk("t6_tb", bus.complete_fu_out[0].take_branch, 1'b1);

        step(0, 0, all, "exact_pre");
        step(0, 0, '0, "exact_drain");
        v = '0; v[0] = all[0]; v[2] = all[2]; v[4] = all[4];
        step(0, 0, v, "exact3");
        chk("exact3_stall", bus.fu_stall, 5'b00000);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                v[i].valid       = 1'($urandom_range(0, 99) < 60);
                v[i].take_branch = 1'($urandom);
                v[i].pr_idx      = 6'($urandom);
                v[i].rob_idx     = 5'($urandom);
            end
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6, v, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
